// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers between EX, MEM and WB:
// occupancy encoding of the two-entry stage and the control-bundle field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // The full layout spans 9 bits; instances that carry mode[2] need CTRL_W >= CTRL_LAYOUT_W.
  localparam int CTRL_REG_WRITE      = 0;
  localparam int CTRL_MEM_WRITE      = 1;
  localparam int CTRL_MEM_READ       = 2;
  localparam int CTRL_RESULT_SRC_LSB = 3;
  localparam int CTRL_RESULT_SRC_W   = 3;
  localparam int CTRL_MODE_LSB       = 6;
  localparam int CTRL_MODE_W         = 3;
  localparam int CTRL_LAYOUT_W       = CTRL_MODE_LSB + CTRL_MODE_W;

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: two-entry skid buffer with registered outputs,
// synchronous flush that clears control bits, and a saturating stall-cycle counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = 8,
  parameter int DATA_W      = 165,
  parameter bit CLEAR_DATA  = 1'b0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_clr,
  output state_e                 dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and its payload stay stable until accepted, and ready never looks at the
  // other side's valid/ready in the same cycle.
  state_e              state;
  logic [CTRL_W-1:0]   main_ctrl, skid_ctrl;
  logic [DATA_W-1:0]   main_data, skid_data;
  logic                in_fire, out_fire;

  assign in_ready  = (state != ST_TWO) & rst_n;
  assign out_valid = (state != ST_EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign dbg_state = state;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // The main ctrl register is zeroed whenever it stops holding a live entry, so
  // out_ctrl reads 0 whenever out_valid is 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLEAR_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state     <= ST_ONE;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            state     <= ST_TWO;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (out_fire) begin
            state     <= ST_EMPTY;
            main_ctrl <= '0;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state     <= ST_ONE;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_ctrl <= '0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          main_ctrl <= '0;
          skid_ctrl <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
